// File: rtl/fir_wlo_pkg.sv
// Shared types and helpers for the word-length optimisation measurement blocks.
package fir_wlo_pkg;

  typedef enum logic [2:0] {ST_IDLE, ST_SKIP, ST_MEAS, ST_DRAIN, ST_DONE} state_t;

  // Widest accumulator/addend the saturation helper can handle.
  localparam int SAT_MAX = 128;

  // Width of the exact reference-minus-DUT difference.
  function automatic int calc_err_wl(input int ref_inte_wl, input int ref_frac_wl);
    return ref_inte_wl + ref_frac_wl + 1;
  endfunction

  // Saturation test for a w-bit unsigned accumulator: 1 when a + b no longer fits in w bits.
  function automatic logic sat_add_ovf(input logic [SAT_MAX-1:0] a, input logic [SAT_MAX-1:0] b,
                                       input int w);
    logic [SAT_MAX:0] sum, lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = {{SAT_MAX{1'b0}}, 1'b1} << w;
    return sum >= lim;
  endfunction

endpackage

// File: rtl/err_sq_pipe.sv
// Aligns DUT and reference samples, subtracts, then registers |diff| and diff^2.
module err_sq_pipe
  import fir_wlo_pkg::*;
#(
  parameter int OUT_INTE_WL = 4,
  parameter int OUT_FRAC_WL = 8,
  parameter int REF_INTE_WL = 8,
  parameter int REF_FRAC_WL = 16
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         in_valid,
  input  logic [OUT_INTE_WL+OUT_FRAC_WL-1:0]           dut_data,
  input  logic [REF_INTE_WL+REF_FRAC_WL-1:0]           ref_data,
  output logic                                         out_valid,
  output logic                                         in_flight,
  output logic [REF_INTE_WL+REF_FRAC_WL:0]             abs_diff,
  output logic [2*(REF_INTE_WL+REF_FRAC_WL+1)-1:0]     diff_sq
);

  localparam int DW     = OUT_INTE_WL + OUT_FRAC_WL;
  localparam int RW     = REF_INTE_WL + REF_FRAC_WL;
  localparam int E      = calc_err_wl(REF_INTE_WL, REF_FRAC_WL);
  localparam int SH     = REF_FRAC_WL - OUT_FRAC_WL;
  localparam int STAGES = 2;

  logic [E-1:0]      dut_al, ref_ext, diff_d, diff_q, abs_d, abs_q;
  logic [2*E-1:0]    sq_q;
  logic [STAGES:1]   vld_pipe;

  // Both operands widened to E bits so the subtraction is exact; abs of the most
  // negative value lands on 2^(E-1), which is still representable unsigned.
  always_comb begin
    dut_al  = {{(E-DW){dut_data[DW-1]}}, dut_data} << SH;
    ref_ext = {{(E-RW){ref_data[RW-1]}}, ref_data};
    diff_d  = ref_ext - dut_al;
    abs_d   = diff_q[E-1] ? (~diff_q + E'(1)) : diff_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      diff_q   <= '0;
      abs_q    <= '0;
      sq_q     <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      if (in_valid) diff_q <= diff_d;
      if (vld_pipe[1]) begin
        abs_q <= abs_d;
        sq_q  <= {{E{1'b0}}, abs_d} * {{E{1'b0}}, abs_d};
      end
    end
  end

  assign out_valid = vld_pipe[STAGES];
  assign in_flight = vld_pipe[1];
  assign abs_diff  = abs_q;
  assign diff_sq   = sq_q;

endmodule

// File: rtl/fir_err_monitor.sv
// Squared/peak error measurement between a reduced-precision FIR and its wide reference,
// with transient skip and a start/busy/done handshake toward the WLO controller.
module fir_err_monitor
  import fir_wlo_pkg::*;
#(
  parameter int OUT_INTE_WL = 4,
  parameter int OUT_FRAC_WL = 8,
  parameter int REF_INTE_WL = 8,
  parameter int REF_FRAC_WL = 16,
  parameter int SKIP        = 15,
  parameter int N_SAMPLES   = 1024,
  parameter int ACC_WL      = 48
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [OUT_INTE_WL+OUT_FRAC_WL-1:0]   dut_data,
  input  logic                                 dut_valid,
  input  logic [REF_INTE_WL+REF_FRAC_WL-1:0]   ref_data,
  input  logic                                 ref_valid,
  output logic                                 busy,
  output logic                                 done,
  output logic [ACC_WL-1:0]                    err_sq_sum,
  output logic [REF_INTE_WL+REF_FRAC_WL:0]     err_max_abs,
  output logic                                 overflow,
  output logic                                 align_err
);

  localparam int E       = calc_err_wl(REF_INTE_WL, REF_FRAC_WL);
  localparam int CNT_MAX = (SKIP > N_SAMPLES) ? SKIP : N_SAMPLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic              pair, start_ok, skip_last, meas_last;
  logic              pipe_valid, pipe_pend, sat;
  logic [E-1:0]      pipe_abs;
  logic [2*E-1:0]    pipe_sq;
  logic [ACC_WL-1:0] acc, acc_nx;
  logic [E-1:0]      max_q;
  logic              ovf_q, aerr_q;

  assign pair      = dut_valid & ref_valid;
  assign start_ok  = start && (state == ST_IDLE || state == ST_DONE);
  assign skip_last = pair && (int'(cnt) == SKIP - 1);
  assign meas_last = pair && (int'(cnt) == N_SAMPLES - 1);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nx = (SKIP == 0) ? ST_MEAS : ST_SKIP;
      ST_SKIP:          if (skip_last) state_nx = ST_MEAS;
      ST_MEAS:          if (meas_last) state_nx = ST_DRAIN;
      // Nothing new enters during DRAIN, so an empty first stage means the
      // last product is being accumulated on this edge.
      ST_DRAIN:         if (!pipe_pend) state_nx = ST_DONE;
      default:          state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ST_SKIP, ST_MEAS, ST_DRAIN: busy = 1'b1;
      ST_DONE:                    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || start_ok)
      cnt <= '0;
    else if ((state == ST_SKIP && skip_last) || (state == ST_MEAS && meas_last))
      cnt <= '0;
    else if ((state == ST_SKIP || state == ST_MEAS) && pair)
      cnt <= cnt + CNT_W'(1);
  end

  err_sq_pipe #(
    .OUT_INTE_WL (OUT_INTE_WL),
    .OUT_FRAC_WL (OUT_FRAC_WL),
    .REF_INTE_WL (REF_INTE_WL),
    .REF_FRAC_WL (REF_FRAC_WL)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (state == ST_MEAS && pair),
    .dut_data  (dut_data),
    .ref_data  (ref_data),
    .out_valid (pipe_valid),
    .in_flight (pipe_pend),
    .abs_diff  (pipe_abs),
    .diff_sq   (pipe_sq)
  );

  // The full-width square feeds the overflow test, so a product wider than
  // the accumulator saturates even though its truncated form might not.
  always_comb begin
    sat    = sat_add_ovf(SAT_MAX'(acc), SAT_MAX'(pipe_sq), ACC_WL);
    acc_nx = sat ? '1 : acc + ACC_WL'(pipe_sq);
  end

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      acc    <= '0;
      max_q  <= '0;
      ovf_q  <= 1'b0;
      aerr_q <= 1'b0;
    end else begin
      if (pipe_valid) begin
        acc <= acc_nx;
        if (sat) ovf_q <= 1'b1;
        if (pipe_abs > max_q) max_q <= pipe_abs;
      end
      if (busy && (dut_valid ^ ref_valid)) aerr_q <= 1'b1;
    end
  end

  assign err_sq_sum  = acc;
  assign err_max_abs = max_q;
  assign overflow    = ovf_q;
  assign align_err   = aerr_q;

endmodule

// File: tb/tb_fir_err_monitor.sv
// Directed bench: three monitor configurations share one sample stream, each started on its own.
module tb_fir_err_monitor;

  logic        clk, rst;
  logic        start_a, start_b, start_c;
  logic [11:0] dut_data;
  logic [23:0] ref_data;
  logic        dut_valid, ref_valid;

  logic        busy_a, done_a, ovf_a, aerr_a;
  logic [47:0] sum_a;
  logic [24:0] max_a;
  logic        busy_b, done_b, ovf_b, aerr_b;
  logic [47:0] sum_b;
  logic [24:0] max_b;
  logic        busy_c, done_c, ovf_c, aerr_c;
  logic [7:0]  sum_c;
  logic [24:0] max_c;

  int checks = 0;
  int passes = 0;

  fir_err_monitor #(.SKIP(2), .N_SAMPLES(4)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .dut_data(dut_data), .dut_valid(dut_valid),
    .ref_data(ref_data), .ref_valid(ref_valid), .busy(busy_a), .done(done_a),
    .err_sq_sum(sum_a), .err_max_abs(max_a), .overflow(ovf_a), .align_err(aerr_a));

  fir_err_monitor #(.SKIP(0), .N_SAMPLES(3)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .dut_data(dut_data), .dut_valid(dut_valid),
    .ref_data(ref_data), .ref_valid(ref_valid), .busy(busy_b), .done(done_b),
    .err_sq_sum(sum_b), .err_max_abs(max_b), .overflow(ovf_b), .align_err(aerr_b));

  fir_err_monitor #(.SKIP(0), .N_SAMPLES(2), .ACC_WL(8)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .dut_data(dut_data), .dut_valid(dut_valid),
    .ref_data(ref_data), .ref_valid(ref_valid), .busy(busy_c), .done(done_c),
    .err_sq_sum(sum_c), .err_max_abs(max_c), .overflow(ovf_c), .align_err(aerr_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are read there too, before the next rising edge.
  task automatic drive(input logic [11:0] d, input logic [23:0] r, input logic dv, input logic rv);
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    dut_data = d; ref_data = r; dut_valid = dv; ref_valid = rv;
  endtask

  task automatic kick(input int w);
    @(negedge clk);
    dut_valid = 1'b0; ref_valid = 1'b0;
    start_a = (w == 0); start_b = (w == 1); start_c = (w == 2);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(12'd0, 24'd0, 1'b0, 1'b0);
    drive(12'd0, 24'd0, 1'b0, 1'b0);
    rst = 1'b0;
    checks++;
    if ({busy_a, done_a, ovf_a, aerr_a, busy_b, done_b, busy_c, done_c} !== 8'b0)
      $display("FAIL reset_flags got %b want 0",
               {busy_a, done_a, ovf_a, aerr_a, busy_b, done_b, busy_c, done_c});
    else passes++;
    checks++;
    if (sum_a !== 48'd0 || max_a !== 25'd0)
      $display("FAIL reset_results got sum=%0d max=%0d want 0/0", sum_a, max_a);
    else passes++;
  endtask

  task automatic test_zero_error;
    kick(0);
    for (int i = 0; i < 6; i++) drive(12'd16, 24'd4096, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive(12'd0, 24'd0, 1'b0, 1'b0);
    checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b0)
      $display("FAIL zero_done got done=%b busy=%b want 1/0", done_a, busy_a);
    else passes++;
    checks++;
    if (sum_a !== 48'd0 || max_a !== 25'd0 || ovf_a !== 1'b0)
      $display("FAIL zero_results got sum=%0d max=%0d ovf=%b want 0/0/0", sum_a, max_a, ovf_a);
    else passes++;
  endtask

  task automatic test_one_lsb;
    kick(0);
    drive(12'd16, 24'd4097, 1'b1, 1'b1);
    checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b1)
      $display("FAIL lsb_restart got done=%b busy=%b want 0/1", done_a, busy_a);
    else passes++;
    for (int i = 0; i < 5; i++) drive(12'd16, 24'd4097, 1'b1, 1'b1);
    // arrives during DRAIN and must not be counted
    drive(12'd16, 24'd4196, 1'b1, 1'b1);
    drive(12'd0, 24'd0, 1'b0, 1'b0);
    checks++;
    if (done_a !== 1'b0) $display("FAIL lsb_done_early got %b want 0", done_a);
    else passes++;
    drive(12'd0, 24'd0, 1'b0, 1'b0);
    checks++;
    if (done_a !== 1'b1) $display("FAIL lsb_done_at3 got %b want 1", done_a);
    else passes++;
    checks++;
    if (sum_a !== 48'd4 || max_a !== 25'd1)
      $display("FAIL lsb_results got sum=%0d max=%0d want 4/1", sum_a, max_a);
    else passes++;
  endtask

  task automatic test_misalign;
    kick(0);
    drive(12'd16, 24'd4097, 1'b1, 1'b1);
    drive(12'd16, 24'd4097, 1'b1, 1'b1);
    drive(12'd16, 24'd4097, 1'b1, 1'b1);
    drive(12'd16, 24'd4097, 1'b1, 1'b1);
    drive(12'd16, 24'd4097, 1'b1, 1'b1);
    start_a = 1'b1;                                // start while busy: ignored
    drive(12'd0, 24'd4097, 1'b1, 1'b0);            // lone DUT sample, dropped
    drive(12'd16, 24'd4097, 1'b1, 1'b1);
    checks++;
    if (aerr_a !== 1'b1) $display("FAIL misalign_flag got %b want 1", aerr_a);
    else passes++;
    drive(12'd0, 24'd0, 1'b0, 1'b0);
    drive(12'd0, 24'd0, 1'b0, 1'b0);
    checks++;
    if (done_a !== 1'b0) $display("FAIL misalign_done_early got %b want 0", done_a);
    else passes++;
    drive(12'd0, 24'd0, 1'b0, 1'b0);
    checks++;
    if (done_a !== 1'b1 || aerr_a !== 1'b1)
      $display("FAIL misalign_done got done=%b aerr=%b want 1/1", done_a, aerr_a);
    else passes++;
    checks++;
    if (sum_a !== 48'd4 || max_a !== 25'd1)
      $display("FAIL misalign_results got sum=%0d max=%0d want 4/1", sum_a, max_a);
    else passes++;
  endtask

  task automatic test_back_to_back;
    kick(0);
    drive(12'd16, 24'd4096, 1'b1, 1'b1);
    checks++;
    if (done_a !== 1'b0 || aerr_a !== 1'b0 || sum_a !== 48'd0 || max_a !== 25'd0)
      $display("FAIL rerun_clear got done=%b aerr=%b sum=%0d max=%0d want 0/0/0/0",
               done_a, aerr_a, sum_a, max_a);
    else passes++;
    for (int i = 0; i < 5; i++) drive(12'd16, 24'd4096, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive(12'd0, 24'd0, 1'b0, 1'b0);
    checks++;
    if (done_a !== 1'b1 || sum_a !== 48'd0 || aerr_a !== 1'b0)
      $display("FAIL rerun_done got done=%b sum=%0d aerr=%b want 1/0/0", done_a, sum_a, aerr_a);
    else passes++;
  endtask

  task automatic test_mixed;
    kick(1);
    drive(12'd16, 24'd4099, 1'b1, 1'b1);           // +3
    drive(12'd16, 24'd4091, 1'b1, 1'b1);           // -5
    drive(12'd16, 24'd4098, 1'b1, 1'b1);           // +2
    drive(12'd0, 24'd0, 1'b0, 1'b0);
    drive(12'd0, 24'd0, 1'b0, 1'b0);
    checks++;
    if (done_b !== 1'b0) $display("FAIL mixed_done_early got %b want 0", done_b);
    else passes++;
    drive(12'd0, 24'd0, 1'b0, 1'b0);
    checks++;
    if (done_b !== 1'b1) $display("FAIL mixed_done got %b want 1", done_b);
    else passes++;
    checks++;
    if (sum_b !== 48'd38 || max_b !== 25'd5)
      $display("FAIL mixed_results got sum=%0d max=%0d want 38/5", sum_b, max_b);
    else passes++;
  endtask

  task automatic test_extreme;
    longint e1, e2, exp_sum;
    e1 = 64'd8388607 + 64'd2048 * 64'd256;        // ref max minus dut min
    e2 = 64'd8388608 + 64'd2047 * 64'd256;        // |ref min minus dut max|
    exp_sum = e1 * e1 + e2 * e2;
    kick(1);
    drive(12'h800, 24'h7FFFFF, 1'b1, 1'b1);
    drive(12'h7FF, 24'h800000, 1'b1, 1'b1);
    drive(12'd16, 24'd4096, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive(12'd0, 24'd0, 1'b0, 1'b0);
    checks++;
    if (max_b !== 25'(e1)) $display("FAIL extreme_max got %0d want %0d", max_b, e1);
    else passes++;
    checks++;
    if (sum_b !== 48'(exp_sum) || ovf_b !== 1'b0 || done_b !== 1'b1)
      $display("FAIL extreme_sum got sum=%0d ovf=%b done=%b want %0d/0/1",
               sum_b, ovf_b, done_b, exp_sum);
    else passes++;
  endtask

  task automatic test_saturation;
    kick(2);
    drive(12'd16, 24'd4112, 1'b1, 1'b1);           // +16 LSB -> 256
    drive(12'd16, 24'd4112, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive(12'd0, 24'd0, 1'b0, 1'b0);
    checks++;
    if (sum_c !== 8'hFF || ovf_c !== 1'b1)
      $display("FAIL sat_results got sum=%0d ovf=%b want 255/1", sum_c, ovf_c);
    else passes++;
    checks++;
    if (max_c !== 25'd16 || done_c !== 1'b1)
      $display("FAIL sat_max got max=%0d done=%b want 16/1", max_c, done_c);
    else passes++;
  endtask

  task automatic test_reset_mid;
    kick(0);
    drive(12'd16, 24'd4097, 1'b1, 1'b1);
    drive(12'd16, 24'd4097, 1'b1, 1'b1);
    drive(12'd16, 24'd4097, 1'b1, 1'b1);           // first measured pair
    drive(12'd16, 24'd4097, 1'b0, 1'b1);           // lone reference sample
    drive(12'd0, 24'd0, 1'b0, 1'b0);
    drive(12'd0, 24'd0, 1'b0, 1'b0);
    checks++;
    if (sum_a !== 48'd1 || aerr_a !== 1'b1 || busy_a !== 1'b1)
      $display("FAIL mid_partial got sum=%0d aerr=%b busy=%b want 1/1/1", sum_a, aerr_a, busy_a);
    else passes++;
    rst = 1'b1;
    drive(12'd16, 24'd4097, 1'b1, 1'b1);
    rst = 1'b0;
    checks++;
    if ({busy_a, done_a, ovf_a, aerr_a} !== 4'b0 || sum_a !== 48'd0 || max_a !== 25'd0)
      $display("FAIL mid_reset got flags=%b sum=%0d max=%0d want 0/0/0",
               {busy_a, done_a, ovf_a, aerr_a}, sum_a, max_a);
    else passes++;
    for (int i = 0; i < 6; i++) drive(12'd16, 24'd4200, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive(12'd0, 24'd0, 1'b0, 1'b0);
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || sum_a !== 48'd0)
      $display("FAIL idle_ignore got busy=%b done=%b sum=%0d want 0/0/0", busy_a, done_a, sum_a);
    else passes++;
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    dut_data = '0; ref_data = '0; dut_valid = 1'b0; ref_valid = 1'b0;
    test_reset;
    test_zero_error;
    test_one_lsb;
    test_misalign;
    test_back_to_back;
    test_mixed;
    test_extreme;
    test_saturation;
    test_reset_mid;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
